// File: rtl/game_phase_ctrl.sv
// game_phase_ctrl: game phase sequencer -- start, ball launch, coil gate timing, ball loss, lives and level tracking
module game_phase_ctrl #(
   parameter int GATE_FRAMES = 15,
   parameter int LOST_FRAMES = 60,
   parameter int LIVES_INIT  = 3,
   parameter int NUM_LEVELS  = 4
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       start_key,
   input  logic       hit_up_triangle,
   input  logic       ball_lost,
   input  logic       level_up,
   output logic       new_game,
   output logic       ball_reload,
   output logic       gate_closed,
   output logic [1:0] lives,
   output logic [1:0] level,
   output logic [2:0] phase,
   output logic       game_over
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      GATE_WAIT = 3'd2,
      PLAY      = 3'd3,
      LOST      = 3'd4,
      OVER      = 3'd5
   } state_t;

   localparam logic [7:0] GATE_CNT  = 8'(GATE_FRAMES);
   localparam logic [7:0] LOST_CNT  = 8'(LOST_FRAMES);
   localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);
   localparam logic [1:0] LEVEL_MAX = 2'(NUM_LEVELS - 1);

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n, cnt_inc;
   logic [1:0] lives_n, level_n;
   logic       gate_n, new_game_n, reload_n;
   logic       start_q, key_valid, press;

   // key_valid blocks a key already held at reset release from counting as a press
   assign press   = start_key & ~start_q & key_valid;
   assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
   assign phase   = state;

   // state, counters and registered outputs
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         lives       <= 2'd0;
         level       <= 2'd0;
         gate_closed <= 1'b0;
         new_game    <= 1'b0;
         ball_reload <= 1'b0;
         game_over   <= 1'b0;
         start_q     <= 1'b0;
         key_valid   <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         lives       <= lives_n;
         level       <= level_n;
         gate_closed <= gate_n;
         new_game    <= new_game_n;
         ball_reload <= reload_n;
         game_over   <= (state_n == OVER);
         start_q     <= start_key;
         key_valid   <= 1'b1;
      end
   end

   // next-state and next-output decisions
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      lives_n    = lives;
      level_n    = level;
      gate_n     = gate_closed;
      new_game_n = 1'b0;
      reload_n   = 1'b0;
      case (state)
         IDLE, OVER: begin
            if (press) begin
               state_n    = LAUNCH;
               lives_n    = LIVES_RST;
               level_n    = 2'd0;
               gate_n     = 1'b0;
               new_game_n = 1'b1;
               reload_n   = 1'b1;
            end
         end
         LAUNCH: begin
            if (hit_up_triangle) begin
               state_n = GATE_WAIT;
               cnt_n   = 8'd0;
            end
         end
         GATE_WAIT: begin
            if (ball_lost) begin
               state_n = LOST;
               cnt_n   = 8'd0;
               lives_n = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
            end else if (startOfFrame) begin
               cnt_n = cnt_inc;
               if (cnt_inc == GATE_CNT) begin
                  state_n = PLAY;
                  gate_n  = 1'b1;
               end
            end
         end
         PLAY: begin
            if (level_up)
               level_n = (level == LEVEL_MAX) ? level : level + 2'd1;
            if (ball_lost) begin
               state_n = LOST;
               cnt_n   = 8'd0;
               lives_n = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
            end
         end
         LOST: begin
            if (startOfFrame) begin
               cnt_n = cnt_inc;
               if (cnt_inc == LOST_CNT) begin
                  if (lives == 2'd0) begin
                     state_n = OVER;
                  end else begin
                     state_n  = LAUNCH;
                     gate_n   = 1'b0;
                     reload_n = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 8'd0;
         end
      endcase
   end

endmodule

// File: doc/game_phase_ctrl.md
GAME_PHASE_CTRL -- requirements
Module: game_phase_ctrl

Interface
REQ-001 Parameter GATE_FRAMES, default 15: frames from launch-triangle hit until the coil-hole gate closes, legal range 1..255.
REQ-002 Parameter LOST_FRAMES, default 60: frames of pause after a ball is lost, legal range 1..255.
REQ-003 Parameter LIVES_INIT, default 3: balls per game, legal range 1..3.
REQ-004 Parameter NUM_LEVELS, default 4: number of playfield levels, legal range 1..4.
REQ-005 clk  in  1  system clock; all state changes occur on the rising edge.
REQ-006 resetN  in  1  asynchronous, active-low reset.
REQ-007 startOfFrame  in  1  one-clk pulse per video frame; the only timebase.
REQ-008 start_key  in  1  level from the start button, synchronous to clk.
REQ-009 hit_up_triangle  in  1  ball struck the launch triangle after leaving the coil.
REQ-010 ball_lost  in  1  ball passed the bottom wall.
REQ-011 level_up  in  1  one-clk pulse from scoring requesting the next level.
REQ-012 new_game  out  1  one-clk pulse at game start.
REQ-013 ball_reload  out  1  one-clk pulse whenever a ball is placed on the coil.
REQ-014 gate_closed  out  1  coil-hole wall drawn and solid.
REQ-015 lives  out  2  balls remaining.
REQ-016 level  out  2  index that selects the level wall colour.
REQ-017 phase  out  3  current state encoding.
REQ-018 game_over  out  1  high while in OVER.

Function
REQ-019 States and phase encodings SHALL be: IDLE=0, LAUNCH=1, GATE_WAIT=2, PLAY=3, LOST=4, OVER=5; values 6 and 7 are unreachable and, if entered, recover to IDLE on the next clk.
REQ-020 start_key SHALL be edge-detected by a register; only a 0->1 transition counts as a press.
REQ-021 A press in IDLE or OVER SHALL, on the same edge:
- go to LAUNCH;
- set lives=LIVES_INIT and level=0;
- clear gate_closed;
- pulse new_game and ball_reload for exactly one clk each.
REQ-022 Presses in any other state SHALL be ignored.
REQ-023 In LAUNCH, hit_up_triangle SHALL move to GATE_WAIT and clear the 8-bit frame counter; hit_up_triangle is ignored in every other state.
REQ-024 In GATE_WAIT, the frame counter SHALL increment on each startOfFrame.
REQ-025 In GATE_WAIT, the startOfFrame that takes the counter to GATE_FRAMES SHALL move to PLAY and set gate_closed=1 on the same edge.
REQ-026 ball_lost in GATE_WAIT or PLAY SHALL:
- move to LOST;
- clear the frame counter;
- decrement lives, saturating at 0.
REQ-027 ball_lost in IDLE, LAUNCH, LOST or OVER SHALL be ignored.
REQ-028 In LOST, the startOfFrame that takes the counter to LOST_FRAMES SHALL:
- go to OVER if lives==0;
- otherwise go to LAUNCH, clear gate_closed and pulse ball_reload.
REQ-029 level_up SHALL be honoured only in PLAY and SHALL increment level, saturating at NUM_LEVELS-1.
REQ-030 level_up and ball_lost together in PLAY SHALL both take effect: level increments and the state moves to LOST.
REQ-031 gate_closed SHALL remain 1 through LOST and OVER until the next LAUNCH entry.
REQ-032 game_over SHALL equal (state==OVER), registered.
REQ-033 The frame counter SHALL hold when startOfFrame is low and SHALL never wrap.

Reset
REQ-034 resetN low SHALL immediately force:
- state IDLE and counter 0;
- lives=0, level=0;
- gate_closed=0, new_game=0, ball_reload=0, game_over=0;
- start_key edge register to 0.
REQ-035 Assertion of reset mid-game SHALL abandon all progress; there are no retained values.
REQ-036 Release of reset SHALL take effect on the first clk edge; a start_key already held high at release does not count as a press.

Verification
REQ-037 Reset, then press start -> new_game and ball_reload pulse one clk; phase=1, lives=3, level=0, gate_closed=0.
REQ-038 Press start, hit_up_triangle, then 15 startOfFrame pulses -> gate_closed rises on the 15th; phase=3; no change after 14 pulses.
REQ-039 In PLAY, ball_lost three times, each followed by 60 frames -> lives 2,1,0; phase returns to 1 twice; after the third loss phase=5 and game_over=1.
REQ-040 In PLAY, five level_up pulses -> level=3, saturated; level_up while in LAUNCH leaves level unchanged.
REQ-041 In PLAY, level_up and ball_lost in the same clk -> level+1, phase=4, lives-1.
REQ-042 Assert resetN during GATE_WAIT at counter=7 -> all outputs take their reset values asynchronously; holding start_key high through reset release causes no game start.
